// File: rtl/trace_obs_pkg.sv
// Shared types and default sizing for the public trace observer and its FIFO.
package trace_obs_pkg;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } obs_state_t;

    localparam int DEF_DATA_W  = 2;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_MAX_GAP = 15;
    localparam int DEF_CNT_W   = 8;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with extended pointers; the head is visible whenever non-empty.
module trace_fifo
    import trace_obs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [DATA_W-1:0]               push_data,
    input  logic                            pop,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    // A pop frees the slot the same cycle, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/public_trace_observer.sv
// Records the stutter-free, repetition-compacted public trace of a codeblock into a FIFO
// and supervises stutter runs for starvation.
module public_trace_observer
    import trace_obs_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int MAX_GAP = DEF_MAX_GAP,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               public_in,
    input  logic                            stutter_in,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_valid,
    output logic [level_width(DEPTH)-1:0]   level,
    output logic [CNT_W-1:0]                events,
    output logic                            overflow,
    output logic                            starved
);

    localparam int GAP_W = $clog2(MAX_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(MAX_GAP + 1);

    obs_state_t        state_q;
    obs_state_t        state_d;
    logic [DATA_W-1:0] last_q;
    logic [GAP_W-1:0]  gap_q;
    logic              push_req;
    logic              push_ok;
    logic              fifo_full;
    logic              fifo_empty;

    trace_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (public_in),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign rd_valid = !fifo_empty;
    assign push_ok  = push_req && (!fifo_full || rd_en);

    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (!stutter_in) begin
                    push_req = 1'b1;
                    state_d  = TRACK;
                end
            end
            TRACK: begin
                push_req = !stutter_in && (public_in != last_q);
            end
            default: state_d = WAIT_FIRST;
        endcase
    end

    // last follows every real step, even when the FIFO drops the record, so compaction tracks the input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_FIRST;
            last_q   <= '0;
            gap_q    <= '0;
            events   <= '0;
            overflow <= 1'b0;
            starved  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!stutter_in) last_q <= public_in;

            if (!stutter_in)          gap_q <= '0;
            else if (gap_q != GAP_SAT) gap_q <= gap_q + 1'b1;
            if (stutter_in && gap_q == GAP_LAST) starved <= 1'b1;

            if (push_ok && events != '1) events <= events + 1'b1;
            if (push_req && fifo_full && !rd_en) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_public_trace_observer.sv
// Directed self-checking bench for public_trace_observer with default parameters.
module tb_public_trace_observer;

    logic       clk;
    logic       rst;
    logic [1:0] public_in;
    logic       stutter_in;
    logic       rd_en;
    logic [1:0] rd_data;
    logic       rd_valid;
    logic [3:0] level;
    logic [7:0] events;
    logic       overflow;
    logic       starved;

    int checks_total  = 0;
    int checks_passed = 0;

    public_trace_observer dut (
        .clk        (clk),
        .rst        (rst),
        .public_in  (public_in),
        .stutter_in (stutter_in),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .level      (level),
        .events     (events),
        .overflow   (overflow),
        .starved    (starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic stut, input logic [1:0] val, input logic rd);
        stutter_in = stut;
        public_in  = val;
        rd_en      = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rd_valid"}, 32'(rd_valid), 0);
        checkOutput({tag, " rd_data"},  32'(rd_data),  0);
        checkOutput({tag, " level"},    32'(level),    0);
        checkOutput({tag, " events"},   32'(events),   0);
        checkOutput({tag, " overflow"}, 32'(overflow), 0);
        checkOutput({tag, " starved"},  32'(starved),  0);
    endtask

    logic [1:0] comp_seq [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

    initial begin
        rst = 1'b1;
        public_in = '0;
        stutter_in = 1'b1;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // Compaction
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, comp_seq[i], 1'b0);
        checkOutput("comp level", 32'(level), 3);
        checkOutput("comp events", 32'(events), 3);
        checkOutput("comp overflow", 32'(overflow), 0);
        checkOutput("comp head0", 32'(rd_data), 1);
        applyStimulus(1'b1, 2'd0, 1'b1);
        checkOutput("comp head1", 32'(rd_data), 2);
        applyStimulus(1'b1, 2'd0, 1'b1);
        checkOutput("comp head2", 32'(rd_data), 3);
        applyStimulus(1'b1, 2'd0, 1'b1);
        checkOutput("comp drained valid", 32'(rd_valid), 0);
        checkOutput("comp drained level", 32'(level), 0);

        // Stutter removal
        pulseReset();
        applyStimulus(1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b0);
        checkOutput("stut level", 32'(level), 1);
        checkOutput("stut events", 32'(events), 1);
        checkOutput("stut rd_data", 32'(rd_data), 1);
        checkOutput("stut starved", 32'(starved), 0);

        // Starvation
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 2'd2, 1'b0);
        checkOutput("starve after 15", 32'(starved), 0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        checkOutput("starve after 16", 32'(starved), 1);
        applyStimulus(1'b0, 2'd1, 1'b0);
        checkOutput("starve sticky", 32'(starved), 1);

        // Full boundary
        pulseReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, (i % 2 == 0) ? 2'd1 : 2'd2, 1'b0);
        checkOutput("full level8", 32'(level), 8);
        checkOutput("full no ovf yet", 32'(overflow), 0);
        applyStimulus(1'b0, 2'd1, 1'b0);
        checkOutput("full level", 32'(level), 8);
        checkOutput("full overflow", 32'(overflow), 1);
        checkOutput("full events", 32'(events), 8);
        applyStimulus(1'b0, 2'd2, 1'b1);
        checkOutput("full pushpop level", 32'(level), 8);
        checkOutput("full pushpop events", 32'(events), 9);
        checkOutput("full pushpop head", 32'(rd_data), 2);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 1'b1);
        checkOutput("mid level5", 32'(level), 5);
        checkOutput("mid overflow", 32'(overflow), 1);
        rst = 1'b1;
        #1;
        checkAllZero("mid async");
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput("mid first level", 32'(level), 1);
        checkOutput("mid first valid", 32'(rd_valid), 1);
        checkOutput("mid first data", 32'(rd_data), 0);

        // Empty pop
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b1);
            checkOutput("empty level", 32'(level), 0);
            checkOutput("empty valid", 32'(rd_valid), 0);
        end
        applyStimulus(1'b0, 2'd2, 1'b1);
        checkOutput("empty push data", 32'(rd_data), 2);
        checkOutput("empty push valid", 32'(rd_valid), 1);
        checkOutput("empty push level", 32'(level), 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/public_trace_observer.md
# public_trace_observer

Observer at the far end of a codeblock's stutter interface. Each cycle it samples the codeblock's registered public output and stutter flag. Non-stuttered steps are compacted modulo repetition: a value is recorded only when it differs from the last recorded one. Recorded values go into a small FIFO that a trace checker drains. It also supervises stutter runs and flags starvation and overflow, so asynchronous hyperproperty benches can compare source and target traces step-for-step after stutter removal.

## Interface
Parameters:
- DATA_W, default 2: width of the public value.
- DEPTH, default 8: FIFO entries; power of two, at least 2.
- MAX_GAP, default 15: longest legal run of consecutive stutter cycles.
- CNT_W, default 8: width of the saturating event counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- public_in  in  DATA_W  codebase public output, already registered.
- stutter_in  in  1  codebase stutter flag; 1 means this cycle is not a step.
- rd_en  in  1  pop request from the checker.
- rd_data  out  DATA_W  FIFO head (first-word fall-through).
- rd_valid  out  1  FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- events  out  CNT_W  number of recorded values, saturating.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.
- starved  out  1  sticky; a stutter run exceeded MAX_GAP.

## Operation
FSM, two states:
- WAIT_FIRST: entered at reset.
  - First cycle with stutter_in=0: push public_in, load last=public_in, go to TRACK.
- TRACK:
  - stutter_in=0 and public_in≠last: push public_in, load last.
  - stutter_in=0 and public_in==last: no push.
  - stutter_in=1: no push, no change to last.

Stutter supervision:
- gap counter clears on any cycle with stutter_in=0.
- On stutter_in=1 it increments, saturating at MAX_GAP+1.
- starved sets when gap reaches MAX_GAP+1.

FIFO:
- Pop on rd_en && rd_valid. rd_en while empty is ignored.
- Push while full with no pop in the same cycle: the value is dropped and overflow sets. last is still updated, so compaction follows the input stream.
- Push and pop in the same cycle while full: both succeed, no overflow, level unchanged.
- Push and pop in the same cycle while empty: the pop is ignored and the push is stored.

events:
- Increments once per successful push, saturating at 2^CNT_W-1.
- Dropped pushes do not count.

Sticky flags: overflow and starved clear only on rst.

Reset (asynchronous, effective immediately):
- state=WAIT_FIRST, last=0, gap=0, FIFO pointers 0.
- Outputs: rd_valid=0, rd_data=0, level=0, events=0, overflow=0, starved=0.
- Reset mid-run discards all FIFO contents. The first non-stutter sample after release is always recorded, even if it equals the pre-reset last value.

Arithmetic:
- FIFO pointers are $clog2(DEPTH)+1 bits with natural wrap. Full when the MSBs differ and the remaining bits are equal.
- All counters are unsigned.

## Timing
- Inputs are sampled on the rising edge of clk.
- A pushed value appears on rd_data/rd_valid and in level in the cycle after its sampling edge (1-cycle latency).
- A pop takes effect at the edge. The next head, or rd_valid=0, is visible in the following cycle.
- events, overflow and starved are registered and update at the same edge as the causing push or gap increment.
- There is no combinational path from public_in or stutter_in to any output. rd_data depends only on registered FIFO state.

## Structure
- Package trace_obs_pkg holds:
  - obs_state_t enum (WAIT_FIRST, TRACK);
  - default DATA_W, DEPTH, MAX_GAP and CNT_W constants;
  - a function computing the level width.
- Sub-module trace_fifo: synchronous first-word-fall-through FIFO with push, pop, full, empty and level. It is parameterised by DATA_W and DEPTH and reset by the same rst.
- The top level holds the FSM, the last register, the gap counter, the event counter and the sticky flags.

## Test plan
- Compaction: after reset, drive stutter_in=0 with public_in 1,1,2,2,2,3 → exactly 1,2,3 popped in order; events=3; overflow=0.
- Stutter removal: public_in 1, stutter_in=1 for 5 cycles while public_in toggles 0/3, then stutter_in=0 with public_in=1 → only one 1 recorded; starved=0.
- Starvation: MAX_GAP=15, hold stutter_in=1 for 16 cycles → starved rises at the edge of the 16th stutter cycle and stays 1 after stutter_in returns to 0.
- Full boundary: DEPTH=8, no reads, push 9 distinct alternating values → level=8, overflow=1, events=8. In a further cycle, a push and a pop on the full FIFO → no new overflow and level stays 8.
- Reset mid-operation: with level=5 and overflow=1, pulse rst asynchronously between edges → all outputs 0 immediately. The next stutter_in=0 sample (public_in=0) is recorded, so level=1 and rd_data=0.
- Empty pop: rd_en=1 while empty for 3 cycles → level stays 0 and rd_valid=0. A simultaneous push of 2 → rd_data=2 and rd_valid=1 on the next cycle.
